// File: rtl/dsp_pkg.sv
// Purpose : shared constants and helpers for the DSP add/subtract datapath.
// Latency : n/a (package only).
// Backpres: n/a (package only).
//
// Contents:
//   OP_ADD / OP_SUB   - encoding of the single-bit op field
//   SAT_W_MAX         - widest operand the saturation helpers can describe
//   sat_max / sat_min - most positive / most negative two's-complement value
//                       of a given width, right-aligned in a SAT_W_MAX vector
package dsp_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Callers truncate the helper results to their own width, so any operand
  // width up to this bound is covered.
  localparam int unsigned SAT_W_MAX = 128;

  // 0111...1 in the low 'width' bits.
  function automatic logic [SAT_W_MAX-1:0] sat_max(input int unsigned width);
    logic [SAT_W_MAX-1:0] ones;
    ones = {SAT_W_MAX{1'b1}};
    return ones >> (SAT_W_MAX - width + 1);
  endfunction

  // 1000...0 in the low 'width' bits.
  function automatic logic [SAT_W_MAX-1:0] sat_min(input int unsigned width);
    logic [SAT_W_MAX-1:0] one;
    one = {{(SAT_W_MAX-1){1'b0}}, 1'b1};
    return one << (width - 1);
  endfunction

endpackage

// File: rtl/dsp_add_segment.sv
// Purpose : SEG-bit combinational ripple segment of the pipelined adder.
// Latency : 0 cycles (pure combinational).
// Backpres: none; the enclosing pipeline decides when results are captured.
//
// Ports:
//   a, b   [SEG-1:0]  segment operands (b already inverted for subtract)
//   cin               carry into bit 0 of the segment
//   sum    [SEG-1:0]  segment result
//   cout              carry out of the segment MSB
//   c_msb             carry into the segment MSB (for signed overflow)
module dsp_add_segment
  import dsp_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  // The low SEG-1 bits are added with one spare bit so that the carry into
  // the MSB falls out directly; the MSB itself is a plain full adder.
  if (SEG == 1) begin : g_single
    assign c_msb = cin;
  end else begin : g_multi
    logic [SEG-1:0] low_sum;
    assign low_sum = {1'b0, a[SEG-2:0]} + {1'b0, b[SEG-2:0]}
                   + {{(SEG-1){1'b0}}, cin};
    assign c_msb          = low_sum[SEG-1];
    assign sum[SEG-2:0]   = low_sum[SEG-2:0];
  end

  assign sum[SEG-1] = a[SEG-1] ^ b[SEG-1] ^ c_msb;
  assign cout       = (a[SEG-1] & b[SEG-1])
                    | (a[SEG-1] & c_msb)
                    | (b[SEG-1] & c_msb);

endmodule

// File: rtl/dsp_pipe_adder.sv
// Purpose : pipelined WIDTH-bit add/subtract, carry chain cut every SEG bits.
// Latency : NSEG = WIDTH/SEG cycles from acceptance to out_valid.
// Backpres: whole pipe freezes while out_valid && !out_ready; in_ready follows.
//
// Build option: define DSP_PIPE_ADDER_SAT_EN to clamp sum to the signed limit
// on overflow (cout and overflow stay raw). Without it sum wraps.
//
// Ports:
//   clk, reset (sync, active low)
//   in_valid / in_ready   operand handshake; op, a, b, cin sampled on accept
//   op                    OP_ADD or OP_SUB from dsp_pkg
//   out_valid / out_ready result handshake
//   sum, cout, overflow   result, raw carry out, signed overflow
//
// WIDTH must be an integer multiple of SEG (and <= SAT_W_MAX when saturating).
module dsp_pipe_adder
  import dsp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSEG = WIDTH / SEG;

`ifdef DSP_PIPE_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

  // Level s registers hold the beat that has completed segment s.
  //   x: result segments 0..s in place, operand-A segments above still raw
  //   y: operand-B (already inverted for SUB) shifted down so the segment the
  //      next stage needs sits at bits [SEG-1:0]
  //   c: carry out of segment s
  //   ovf: carry-in-to-MSB ^ carry-out; only the last level's copy is meaningful
  logic [NSEG-1:0]  vld_q, vld_d;
  logic [NSEG-1:0]  c_q,   c_d;
  logic             ovf_q [NSEG];
  logic             ovf_d [NSEG];
  logic [WIDTH-1:0] x_q   [NSEG];
  logic [WIDTH-1:0] x_d   [NSEG];
  logic [WIDTH-1:0] y_q   [NSEG];
  logic [WIDTH-1:0] y_d   [NSEG];

  // Stage inputs: stage 0 reads the ports, stage s reads level s-1.
  logic [WIDTH-1:0] x_in  [NSEG];
  logic [WIDTH-1:0] y_in  [NSEG];
  logic             c_in  [NSEG];
  logic             v_in  [NSEG];

  logic [SEG-1:0]   seg_sum [NSEG];
  logic             seg_co  [NSEG];
  logic             seg_cm  [NSEG];

  logic             en;

  // Every stage advances together; a stalled output freezes the whole pipe,
  // so bubbles are preserved rather than squeezed out.
  assign en        = !vld_q[NSEG-1] || out_ready;
  assign in_ready  = en || !reset;

  assign out_valid = vld_q[NSEG-1];
  assign sum       = x_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
  assign overflow  = ovf_q[NSEG-1];

  always_comb begin : stage_inputs
    x_in[0] = a;
    y_in[0] = (op == OP_SUB) ? ~b : b;
    c_in[0] = cin;
    v_in[0] = in_valid;
    for (int s = 1; s < NSEG; s++) begin
      x_in[s] = x_q[s-1];
      y_in[s] = y_q[s-1];
      c_in[s] = c_q[s-1];
      v_in[s] = vld_q[s-1];
    end
  end

  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    dsp_add_segment #(
      .SEG (SEG)
    ) u_add (
      .a     (x_in[s][s*SEG +: SEG]),
      .b     (y_in[s][SEG-1:0]),
      .cin   (c_in[s]),
      .sum   (seg_sum[s]),
      .cout  (seg_co[s]),
      .c_msb (seg_cm[s])
    );
  end

  always_comb begin : stage_next
    for (int s = 0; s < NSEG; s++) begin
      vld_d[s] = vld_q[s];
      c_d[s]   = c_q[s];
      ovf_d[s] = ovf_q[s];
      x_d[s]   = x_q[s];
      y_d[s]   = y_q[s];
      if (en) begin
        vld_d[s] = v_in[s];
        // Data only moves with a valid beat; bubbles leave the data
        // registers untouched, which also keeps the outputs at zero after
        // reset until the first real result arrives.
        if (v_in[s]) begin
          x_d[s]                = x_in[s];
          x_d[s][s*SEG +: SEG]  = seg_sum[s];
          y_d[s]                = y_in[s] >> SEG;
          c_d[s]                = seg_co[s];
          ovf_d[s]              = seg_co[s] ^ seg_cm[s];
        end
      end
    end
`ifdef DSP_PIPE_ADDER_SAT_EN
    // A raw MSB of 1 on overflow means two positives wrapped negative.
    if (en && v_in[NSEG-1] && ovf_d[NSEG-1]) begin
      x_d[NSEG-1] = x_d[NSEG-1][WIDTH-1] ? SAT_MAX : SAT_MIN;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int s = 0; s < NSEG; s++) begin
        ovf_q[s] <= 1'b0;
        x_q[s]   <= '0;
        y_q[s]   <= '0;
      end
    end else begin
      vld_q <= vld_d;
      c_q   <= c_d;
      for (int s = 0; s < NSEG; s++) begin
        ovf_q[s] <= ovf_d[s];
        x_q[s]   <= x_d[s];
        y_q[s]   <= y_d[s];
      end
    end
  end

endmodule

// File: tb/tb_dsp_pipe_adder.sv
// Purpose : scoreboard bench for dsp_pipe_adder at WIDTH=16, SEG=8.
// Latency : expects results 2 cycles after acceptance.
// Backpres: drives a 3-cycle out_ready stall mid-stream.
module tb_dsp_pipe_adder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  dsp_pipe_adder #(
    .WIDTH (16),
    .SEG   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          id;
  } exp_t;

  vec_t vecs [12];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;

`ifdef DSP_PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic o, input logic [15:0] va,
                         input logic [15:0] vb, input logic c, input logic [15:0] s,
                         input logic co, input logic ov);
    vecs[i].op = o;  vecs[i].a  = va; vecs[i].b  = vb; vecs[i].cin = c;
    vecs[i].s  = s;  vecs[i].co = co; vecs[i].ov = ov;
  endtask

  // Present one beat starting just after a rising edge; returns just after
  // the edge that accepted it. Expected result is queued only when tracked.
  task automatic send(input int i, input bit track);
    exp_t e;
    in_valid = 1'b1;
    op       = vecs[i].op;
    a        = vecs[i].a;
    b        = vecs[i].b;
    cin      = vecs[i].cin;
    for (int t = 0; t <= 200; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t == 200) begin
        n_checks++;
        n_err++;
        $display("FAIL accept_timeout beat%0d: in_ready stuck at %0b, expected 1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    if (track) begin
      e.s  = vecs[i].s;
      e.co = vecs[i].co;
      e.ov = vecs[i].ov;
      e.id = i;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: pop on transfer; while stalled the held result must already
  // equal the head of the queue and in_ready must be low.
  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_output: got sum=0x%0h with no beat outstanding, expected none", sum);
      end else if (out_ready) begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("beat%0d_sum", e.id), 32'(sum), 32'(e.s));
        chk($sformatf("beat%0d_cout", e.id), 32'(cout), 32'(e.co));
        chk($sformatf("beat%0d_ovf", e.id), 32'(overflow), 32'(e.ov));
      end else begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk($sformatf("hold_beat%0d_sum", sb_q[0].id), 32'(sum), 32'(sb_q[0].s));
        chk($sformatf("hold_beat%0d_cout", sb_q[0].id), 32'(cout), 32'(sb_q[0].co));
        chk($sformatf("hold_beat%0d_ovf", sb_q[0].id), 32'(overflow), 32'(sb_q[0].ov));
      end
    end
  end

  task automatic drain();
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(posedge clk);
    chk("drain_outstanding", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    //       idx op   a         b         cin sum                      cout ov
    set_vec(0,  1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100,                1'b0, 1'b0);
    set_vec(1,  1'b0, 16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
    set_vec(2,  1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE,                1'b0, 1'b0);
    set_vec(3,  1'b1, 16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
    set_vec(4,  1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345,                1'b0, 1'b0);
    set_vec(5,  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000,                1'b1, 1'b0);
    set_vec(6,  1'b1, 16'h0010, 16'h0010, 1'b1, 16'h0000,                1'b1, 1'b0);
    set_vec(7,  1'b0, 16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1);
    set_vec(8,  1'b0, 16'h0001, 16'h0002, 1'b1, 16'h0004,                1'b0, 1'b0);
    set_vec(9,  1'b1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF,                1'b0, 1'b0);
    set_vec(10, 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100,                1'b0, 1'b0);
    set_vec(11, 1'b0, 16'h4000, 16'h4000, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);

    // Reset held low for 3 edges while a valid beat is offered.
    reset     = 1'b0;
    in_valid  = 1'b1;
    op        = 1'b0;
    a         = 16'h1111;
    b         = 16'h2222;
    cin       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    mon_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Cross-segment carry, with the 2-cycle latency checked explicitly.
    send(0, 1'b1);
    @(negedge clk);
    chk("latency_cycle1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_cycle2_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Signed overflow and subtract cases.
    for (int i = 1; i <= 3; i++) send(i, 1'b1);
    drain();
    @(posedge clk);
    #1;

    // Six back-to-back beats with a 3-cycle out_ready stall mid-stream.
    fork
      begin
        for (int i = 4; i <= 9; i++) send(i, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send(10, 1'b1);
    send(11, 1'b1);
    drain();
    @(posedge clk);
    #1;

    // Reset with two valid beats in flight; neither may ever appear.
    mon_en    = 1'b0;
    out_ready = 1'b0;
    send(4, 1'b0);
    send(5, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_sum", 32'(sum), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_ghost_out_valid", 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dsp_pipe_adder.md
# dsp_pipe_adder

Parametrised, pipelined add/subtract unit for the DSP datapath. It generalises the fixed 16-bit adder stage to any width. The carry chain is split into registered segments so wide operands close timing at full clock rate. A valid/ready handshake and a signed overflow flag are added. It sits between operand sources and downstream DSP logic, and provides an optional signed-saturation mode.

## Interface
- WIDTH, 16: operand/result width in bits.
- SEG, 8: carry-segment width per pipeline stage; WIDTH must be an integer multiple of SEG.
- NSEG (localparam), WIDTH/SEG: pipeline depth.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- op  input  1  0 = ADD, 1 = SUB (encoding from package).
- a  input  WIDTH  operand A, two's complement.
- b  input  WIDTH  operand B, two's complement.
- cin  input  1  carry in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (raw, never saturated).
- overflow  output  1  signed overflow of this result.

## Operation
- ADD: {cout,sum} = a + b + cin. SUB: {cout,sum} = a + ~b + cin, so cin=1 gives exact a−b and cout=1 means no borrow.
- Stage k (0..NSEG-1) adds segment k using the registered carry from stage k−1. Higher operand segments are skewed forward through registers, and completed lower result segments are deskewed, so all bits of one beat exit together.
- overflow = carry into MSB XOR carry out of MSB. It is computed in the last stage.
- Each stage carries a valid bit. Global advance enable is en = !out_valid || out_ready. When en is low, every stage and skew register holds. Bubbles are not compressed.
- in_ready = en. A beat is accepted when in_valid && in_ready. When en is high and in_valid is low, a bubble (valid=0) enters stage 0.
- Result transfer occurs on out_valid && out_ready.
- Beats exit strictly in acceptance order. No beat is dropped or duplicated.
- Operands and op are sampled only at acceptance. Changes while in_ready is low have no effect.

## Timing
- Latency: NSEG cycles from acceptance to out_valid, with no backpressure. SEG=WIDTH gives latency 1.
- Throughput: 1 beat/cycle while out_ready is high.
- Reset (reset low at a clk edge): all stage valids clear. out_valid, sum, cout and overflow read 0 from the next cycle. in_ready reads 1 during and after reset.
- Reset mid-operation: in-flight beats are discarded and never emitted.
- Simultaneous output transfer and input acceptance in the same cycle is legal, with no bubble inserted.
- out_valid high with out_ready low holds sum, cout and overflow stable until transfer.

## Configuration
- DSP_PIPE_ADDER_SAT_EN defined: on overflow, sum clamps to the signed limit. Positive overflow gives 0111…1; negative overflow gives 1000…0. Clamping is applied in the last stage with no added latency. cout and overflow are unchanged.
- DSP_PIPE_ADDER_SAT_EN undefined: sum wraps modulo 2^WIDTH. The port list is identical in both builds.

## Structure
- Shared package dsp_pkg:
  - op encoding constants OP_ADD and OP_SUB.
  - function sat_max(WIDTH) / sat_min(WIDTH).
- One sub-module: dsp_add_segment. It is a SEG-bit combinational adder with inputs a, b, cin and outputs sum, cout, and carry into its MSB. The top level instantiates it NSEG times with the pipeline registers.

## Test plan
All scenarios use WIDTH=16, SEG=8, so latency is 2.
- Reset: hold reset low 3 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, overflow=0, in_ready=1; no output ever appears for those beats.
- Cross-segment carry: ADD a=0x00FF, b=0x0001, cin=0 → 2 cycles later sum=0x0100, cout=0, overflow=0.
- Signed overflow: ADD a=0x7FFF, b=0x0001 → overflow=1, cout=0. sum is 0x8000 without the macro and 0x7FFF with DSP_PIPE_ADDER_SAT_EN.
- Subtract: SUB a=0x0005, b=0x0007, cin=1 → sum=0xFFFE, cout=0, overflow=0. SUB a=0x8000, b=0x0001, cin=1 → overflow=1.
- Backpressure: stream 6 back-to-back beats with out_ready low for 3 cycles mid-stream → in_ready low while stalled, outputs held stable, all 6 results in order with no loss or duplication.
- Reset mid-flight: assert reset with 2 valid beats in the pipe → out_valid=0 next cycle; neither beat is emitted after reset releases.
